// File: rtl/avalon_idct.sv
// Avalon-MM inverse DCT peripheral: the CPU loads a power-of-two block of coefficients,
// and samples are reconstructed with NUM_TERMS_PER_CYCLE multiply-accumulates per cycle.
module avalon_idct #(
  parameter int MAX_SIZE            = 64,
  parameter int HEIGHT              = $clog2(MAX_SIZE),
  parameter int NBITS               = 16,
  parameter int NUM_TERMS_PER_CYCLE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [NBITS-1:0] writedata,
  output logic [NBITS-1:0] out,
  output logic             done
);

  localparam int unsigned AW    = HEIGHT;           // sample/coefficient index
  localparam int unsigned SW    = HEIGHT + 1;       // size and counters up to MAX_SIZE
  localparam int unsigned IW    = HEIGHT + 1;       // cosine index 0..2*MAX_SIZE-1
  localparam int unsigned JW    = HEIGHT + 2;       // term start, may overshoot size
  localparam int unsigned PW    = $clog2(HEIGHT + 1);
  localparam int unsigned ACC_W = 32;
  localparam int unsigned T     = NUM_TERMS_PER_CYCLE;
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (NBITS - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - (ACC_W+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_DONE} state_t;

  state_t                   state;
  logic [NBITS-1:0]         coeff  [MAX_SIZE];
  logic [NBITS-1:0]         result [MAX_SIZE];
  logic [MAX_SIZE-1:0]      result_valid;
  logic [SW-1:0]            size, k, n;
  logic [PW-1:0]            power, start_power;
  logic [JW-1:0]            j;
  logic signed [ACC_W-1:0]  acc, step_sum;
  logic signed [ACC_W-1:0]  term [T];
  logic signed [ACC_W:0]    scaled;
  logic [NBITS-1:0]         sat_val;
  logic [NBITS-1:0]         q_m;
  logic                     wr_setq, wr_start, wr_data, calc_step, commit;
  logic                     in_range;
  logic                     unused_ok;

  // Quarter-wave of the shared cosine ROM: round(32767*cos(pi*q/64)), q = 0..32.
  function automatic logic [NBITS-1:0] cos_quarter(input logic [AW-1:0] q);
    case (q)
      6'd0:  cos_quarter = 16'd32767;  6'd1:  cos_quarter = 16'd32728;
      6'd2:  cos_quarter = 16'd32609;  6'd3:  cos_quarter = 16'd32412;
      6'd4:  cos_quarter = 16'd32137;  6'd5:  cos_quarter = 16'd31785;
      6'd6:  cos_quarter = 16'd31356;  6'd7:  cos_quarter = 16'd30852;
      6'd8:  cos_quarter = 16'd30273;  6'd9:  cos_quarter = 16'd29621;
      6'd10: cos_quarter = 16'd28898;  6'd11: cos_quarter = 16'd28105;
      6'd12: cos_quarter = 16'd27245;  6'd13: cos_quarter = 16'd26319;
      6'd14: cos_quarter = 16'd25329;  6'd15: cos_quarter = 16'd24279;
      6'd16: cos_quarter = 16'd23170;  6'd17: cos_quarter = 16'd22005;
      6'd18: cos_quarter = 16'd20787;  6'd19: cos_quarter = 16'd19519;
      6'd20: cos_quarter = 16'd18204;  6'd21: cos_quarter = 16'd16846;
      6'd22: cos_quarter = 16'd15446;  6'd23: cos_quarter = 16'd14010;
      6'd24: cos_quarter = 16'd12539;  6'd25: cos_quarter = 16'd11039;
      6'd26: cos_quarter = 16'd9512;   6'd27: cos_quarter = 16'd7962;
      6'd28: cos_quarter = 16'd6393;   6'd29: cos_quarter = 16'd4808;
      6'd30: cos_quarter = 16'd3212;   6'd31: cos_quarter = 16'd1608;
      default: cos_quarter = 16'd0;
    endcase
  endfunction

  // Full-period table by folding: cos[i] = cos[2N-i], and cos[N-q] = -cos[q].
  function automatic logic signed [NBITS-1:0] cos_lut(input logic [IW-1:0] idx);
    logic [IW-1:0] i;
    logic [AW-1:0] q;
    logic          neg;
    i   = (idx > IW'(MAX_SIZE)) ? IW'(32'(2 * MAX_SIZE) - 32'(idx)) : idx;
    neg = (i > IW'(MAX_SIZE / 2));
    q   = neg ? AW'(32'(MAX_SIZE) - 32'(i)) : AW'(i);
    cos_lut = neg ? -$signed(cos_quarter(q)) : $signed(cos_quarter(q));
  endfunction

  assign wr_setq   = write && (address == 8'd2);
  assign wr_start  = write && (address == 8'd0);
  assign wr_data   = write && (address == 8'd1);
  assign calc_step = (state == S_CALC) && !(wr_setq || wr_start || wr_data);
  assign commit    = calc_step && (j >= JW'(size));
  assign unused_ok = ^q_m;

  // Negative exponents clamp to 0, oversize ones to HEIGHT.
  always_comb begin
    start_power = '0;
    if (!writedata[NBITS-1]) begin
      if (writedata > NBITS'(HEIGHT)) start_power = PW'(HEIGHT);
      else                            start_power = PW'(writedata);
    end
  end

  for (genvar t = 0; t < T; t++) begin : g_mac
    logic [JW-1:0]              kk;
    logic [IW-1:0]              idx;
    logic signed [2*NBITS-1:0]  prod;
    assign kk   = j + JW'(t);
    assign idx  = IW'((32'({n, 1'b1}) * 32'(kk) * 32'(MAX_SIZE)) >> (32'(power) + 32'd1));
    assign prod = $signed(coeff[kk[AW-1:0]]) * cos_lut(idx);
    // DC term carries an extra halving; shifts floor toward minus infinity.
    assign term[t] = (kk >= JW'(size)) ? '0 :
                     (kk == '0) ? ACC_W'(prod >>> NBITS) : ACC_W'(prod >>> (NBITS - 1));
  end

  always_comb begin
    step_sum = '0;
    for (int t = 0; t < T; t++) step_sum = step_sum + term[t];
  end

  always_comb begin
    scaled  = $signed({acc, 1'b0}) >>> power;
    if (scaled > SAT_MAX)      sat_val = NBITS'(SAT_MAX);
    else if (scaled < SAT_MIN) sat_val = NBITS'(SAT_MIN);
    else                       sat_val = NBITS'(scaled);
  end

  // Control state, counters and accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      size         <= '0;
      power        <= '0;
      k            <= '0;
      n            <= '0;
      j            <= '0;
      acc          <= '0;
      result_valid <= '0;
      q_m          <= '0;
    end else if (wr_setq) begin
      q_m <= writedata;
    end else if (wr_start) begin
      power        <= start_power;
      size         <= SW'(1) << start_power;
      k            <= '0;
      result_valid <= '0;
      state        <= S_LOAD;
    end else if (wr_data) begin
      if (state == S_LOAD) begin
        k <= k + SW'(1);
        if (k == size - SW'(1)) begin
          n     <= '0;
          j     <= '0;
          acc   <= '0;
          state <= S_CALC;
        end
      end
    end else if (calc_step) begin
      if (!commit) begin
        acc <= acc + step_sum;
        j   <= j + JW'(T);
      end else begin
        result_valid[n[AW-1:0]] <= 1'b1;
        acc <= '0;
        j   <= '0;
        n   <= n + SW'(1);
        if (n == size - SW'(1)) state <= S_DONE;
      end
    end
  end

  // Coefficient and result storage need no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (wr_data && (state == S_LOAD)) coeff[k[AW-1:0]] <= writedata;
    if (commit)                       result[n[AW-1:0]] <= sat_val;
  end

  assign in_range = (address < 8'(size));
  assign out      = (read && in_range) ? result[address[AW-1:0]] : '0;
  assign done     = !read || !in_range || result_valid[address[AW-1:0]];

endmodule

// File: tb/tb_avalon_idct.sv
// Scoreboarded bench for avalon_idct: reads push expected samples, a negedge monitor
// pops and compares whenever a read completes (read high and done high).
module tb_avalon_idct;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  address;
  logic        read;
  logic        write;
  logic [15:0] writedata;
  logic [15:0] out;
  logic        done;

  typedef struct {
    string name;
    int    addr;
    int    value;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   acks     = 0;
  int   stalls;

  always #5 clk = ~clk;

  avalon_idct dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .out       (out),
    .done      (done)
  );

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  // Monitor: a read completes on any negedge where read and done are both high.
  always @(negedge clk) begin
    if (read && done && !reset) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read: addr %0d out %0d, required no completion", address, $signed(out));
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "_addr"}, int'(address), mon_e.addr);
        check(mon_e.name, int'($signed(out)), mon_e.value);
      end
      acks++;
    end
  end

  task automatic do_write(input int addr, input int data);
    address   = 8'(addr);
    writedata = 16'(data);
    write     = 1'b1;
    @(posedge clk);
    #1;
    write = 1'b0;
  endtask

  // Issue a read, push its expectation, and count the negedges it spends stalled.
  task automatic do_read(input string name, input int addr, input int value,
                         input int budget, output int n_stall);
    int   a0;
    exp_t e;
    e.name  = name;
    e.addr  = addr;
    e.value = value;
    exp_q.push_back(e);
    a0      = acks;
    address = 8'(addr);
    read    = 1'b1;
    n_stall = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      #1;
      if (acks != a0) break;
      n_stall++;
    end
    if (acks == a0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: done still low after %0d cycles, required high", name, budget);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    read = 1'b0;
  endtask

  task automatic rd(input string name, input int addr, input int value);
    int s;
    do_read(name, addr, value, 100, s);
  endtask

  // Read that must stall right now; the read is withdrawn afterwards.
  task automatic probe_stall(input string name, input int addr);
    address = 8'(addr);
    read    = 1'b1;
    @(negedge clk);
    check(name, int'(done), 0);
    #1;
    read = 1'b0;
  endtask

  task automatic load_block(input int pow, input int c0, input int c1, input int c2, input int c3);
    int c[4];
    c = '{c0, c1, c2, c3};
    do_write(0, pow);
    for (int i = 0; i < (1 << pow); i++) do_write(1, c[i]);
  endtask

  initial begin
    reset     = 1'b1;
    address   = '0;
    read      = 1'b0;
    write     = 1'b0;
    writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state: nothing loaded, read returns 0 without stalling.
    do_read("rst_x0", 0, 0, 20, stalls);
    check("rst_stall", stalls, 0);

    // DC-only block of 4: every sample 1023, last one valid 8 cycles after the last write.
    load_block(2, 4096, 0, 0, 0);
    do_read("dc4_x3", 3, 1023, 50, stalls);
    check("dc4_latency", stalls, 8);
    rd("dc4_x0", 0, 1023);
    rd("dc4_x1", 1, 1023);
    rd("dc4_x2", 2, 1023);
    do_read("dc4_x5", 5, 0, 20, stalls);
    check("dc4_x5_stall", stalls, 0);

    // Size 2, pure k=1 term.
    load_block(1, 0, 8192, 0, 0);
    rd("k1_x0", 0, 5792);
    rd("k1_x1", 1, -5793);

    // Size 4, pure k=2 term: exercises cosine index wrap.
    load_block(2, 0, 0, 8192, 0);
    rd("k2_x0", 0, 2896);
    rd("k2_x1", 1, -2897);
    rd("k2_x2", 2, -2897);
    rd("k2_x3", 3, 2896);

    // Saturation.
    load_block(1, 32767, 32767, 0, 0);
    rd("sat_x0", 0, 32767);
    rd("sat_x1", 1, -6787);

    // Size 1, most negative coefficient.
    load_block(0, -32768, 0, 0, 0);
    rd("neg_x0", 0, -32768);
    do_read("neg_x5", 5, 0, 20, stalls);
    check("neg_x5_stall", stalls, 0);

    // START during CALC aborts: results invalid until the new block is computed.
    load_block(2, 4096, 0, 0, 0);
    do_write(0, 1);
    probe_stall("abort_x0_stall", 0);
    do_write(1, 0);
    do_write(1, 8192);
    do_read("abort_x0", 0, 5792, 50, stalls);
    check("abort_latency", stalls, 2);

    // DATA write during CALC is ignored.
    load_block(1, 0, 8192, 0, 0);
    do_write(1, 1234);
    rd("ign_x0", 0, 5792);
    rd("ign_x1", 1, -5793);

    // Oversize exponent clamps to 64 samples.
    do_write(0, 9);
    probe_stall("clamp_x63_stall", 63);
    do_read("clamp_x64", 64, 0, 20, stalls);
    check("clamp_x64_stall", stalls, 0);
    do_write(1, 4096);
    for (int i = 1; i < 64; i++) do_write(1, 0);
    do_read("clamp_x63", 63, 63, 700, stalls);
    check("clamp_latency", stalls, 576);
    rd("clamp_x0", 0, 63);

    // Reset mid-CALC.
    load_block(2, 4096, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    do_read("rstc_x0", 0, 0, 20, stalls);
    check("rstc_x0_stall", stalls, 0);
    do_read("rstc_x2", 2, 0, 20, stalls);
    check("rstc_x2_stall", stalls, 0);
    load_block(1, 0, 8192, 0, 0);
    rd("rstc_new_x1", 1, -5793);
    rd("rstc_new_x0", 0, 5792);

    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
